// File: rtl/i2s_clip_player.sv
// Mono I2S clip player: streams a CLIP_LEN-entry sample buffer, one sample per
// 64-slot frame, duplicated to left and right, with mute and graceful stop.
module i2s_clip_player #(
   parameter int  CLIP_LEN    = 64,
   parameter int  SAMPLE_BITS = 16,
   localparam int AW          = $clog2(CLIP_LEN)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   play_en,
   input  logic                   clip_valid,
   output logic [AW-1:0]          smp_addr,
   input  logic [SAMPLE_BITS-1:0] smp_data,
   output logic                   audio_I2S_bclk,
   output logic                   audio_I2S_pblrc,
   output logic                   audio_I2S_pbdat,
   output logic                   busy,
   output logic                   frame_pulse,
   output logic                   clip_wrap,
   output logic [15:0]            mute_cnt
);
   typedef enum logic [1:0] {IDLE, PREFETCH, PLAY, STOPPING} state_t;
   localparam logic [5:0] SB = 6'(SAMPLE_BITS);

   state_t                 state, state_nxt;
   logic [1:0]             div;
   logic [5:0]             slot, nxt_slot, bit_idx;
   logic [4:0]             half;
   logic                   pf_cnt, mute;
   logic [SAMPLE_BITS-1:0] sample, pending, bit_sel;
   logic                   running, frame_end, fetch_adv, fetch_lat;
   logic                   pf_done, stop_now, nxt_bit;

   // bclk and word select come straight off the divider/slot flops
   assign audio_I2S_bclk  = div[1];
   assign audio_I2S_pblrc = slot[5];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (play_en && clip_valid) state_nxt = PREFETCH;
         PREFETCH: if (pf_cnt) state_nxt = PLAY;
         PLAY:     if (!play_en) state_nxt = STOPPING;
         STOPPING: if (play_en) state_nxt = PLAY;
                   else if (frame_end) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      running   = (state == PLAY) || (state == STOPPING);
      frame_end = running && (div == 2'd3) && (slot == 6'd63);
      fetch_adv = running && (div == 2'd0) && (slot == 6'd63);
      fetch_lat = running && (div == 2'd2) && (slot == 6'd63);
      pf_done   = (state == PREFETCH) && pf_cnt;
      stop_now  = (state == STOPPING) && !play_en && frame_end;
      // bit for the slot about to start; one-bit I2S delay puts the MSB in slot 1
      nxt_slot  = slot + 6'd1;
      half      = nxt_slot[4:0];
      bit_idx   = SB - {1'b0, half};
      bit_sel   = SAMPLE_BITS'(1) << bit_idx;
      nxt_bit   = 1'b0;
      if (!mute && (half != 5'd0) && ({1'b0, half} <= SB))
         nxt_bit = |(sample & bit_sel);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div             <= 2'd0;
         slot            <= 6'd0;
         pf_cnt          <= 1'b0;
         mute            <= 1'b0;
         sample          <= '0;
         pending         <= '0;
         smp_addr        <= '0;
         audio_I2S_pbdat <= 1'b0;
         busy            <= 1'b0;
         frame_pulse     <= 1'b0;
         clip_wrap       <= 1'b0;
         mute_cnt        <= 16'd0;
      end else begin
         busy        <= (state_nxt != IDLE);
         frame_pulse <= 1'b0;
         clip_wrap   <= 1'b0;
         case (state)
            IDLE: begin
               div             <= 2'd0;
               slot            <= 6'd0;
               pf_cnt          <= 1'b0;
               smp_addr        <= '0;
               audio_I2S_pbdat <= 1'b0;
            end
            PREFETCH: begin
               pf_cnt <= 1'b1;
               if (pf_done) begin
                  sample      <= smp_data;
                  mute        <= 1'b0;
                  frame_pulse <= 1'b1;
               end
            end
            default: begin
               div <= div + 2'd1;
               if (div == 2'd3) begin
                  slot            <= nxt_slot;
                  audio_I2S_pbdat <= nxt_bit;
               end
               if (fetch_adv) begin
                  smp_addr  <= smp_addr + AW'(1);
                  clip_wrap <= &smp_addr;
               end
               if (fetch_lat) pending <= smp_data;
               // the mute decision is taken once per frame so a mid-frame drop is ignored
               if (frame_end) begin
                  if (stop_now) smp_addr <= '0;
                  else begin
                     sample      <= pending;
                     mute        <= !clip_valid;
                     frame_pulse <= 1'b1;
                     if (!clip_valid && (mute_cnt != 16'hFFFF))
                        mute_cnt <= mute_cnt + 16'd1;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_i2s_clip_player.sv
// Bench for i2s_clip_player: time-indexed playback model plus directed scenarios
// (long run with wraps, muting, stop/resume, mid-frame reset).
module tb_i2s_clip_player;
   logic        clk, rst, play_en, clip_valid;
   logic [5:0]  smp_addr;
   logic [15:0] smp_data;
   logic        bclk, pblrc, pbdat, busy, frame_pulse, clip_wrap;
   logic [15:0] mute_cnt;

   i2s_clip_player #(.CLIP_LEN(64), .SAMPLE_BITS(16)) dut (
      .clk(clk), .rst(rst), .play_en(play_en), .clip_valid(clip_valid),
      .smp_addr(smp_addr), .smp_data(smp_data),
      .audio_I2S_bclk(bclk), .audio_I2S_pblrc(pblrc), .audio_I2S_pbdat(pbdat),
      .busy(busy), .frame_pulse(frame_pulse), .clip_wrap(clip_wrap),
      .mute_cnt(mute_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // sample buffer with one-cycle read latency
   logic [15:0] mem [0:63];
   always @(posedge clk) smp_data <= mem[smp_addr];

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // model: phase 0 idle, 1 prefetch, 2 playing; m_t counts clk since first play cycle
   int          m_phase, m_pf, m_t;
   logic        m_mute, m_stop;
   logic [15:0] m_mc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0; m_pf <= 0; m_t <= 0; m_mute <= 1'b0; m_stop <= 1'b0; m_mc <= 16'd0;
      end else begin
         case (m_phase)
            0: if (play_en && clip_valid) begin m_phase <= 1; m_pf <= 0; end
            1: if (m_pf == 0) m_pf <= 1;
               else begin m_phase <= 2; m_t <= 0; m_mute <= 1'b0; m_stop <= 1'b0; end
            default: begin
               m_stop <= !play_en;
               if ((m_t % 256 == 255) && m_stop && !play_en) m_phase <= 0;
               else begin
                  m_t <= m_t + 1;
                  if (m_t % 256 == 255) begin
                     m_mute <= !clip_valid;
                     if (!clip_valid && m_mc != 16'hFFFF) m_mc <= m_mc + 16'd1;
                  end
               end
            end
         endcase
      end
   end

   function automatic logic [27:0] exp_vec();
      logic [5:0]  a;
      logic        bc, lr, dat, fp, cw;
      logic [15:0] smp;
      int          s, ft, f, half;
      a = 6'd0; bc = 1'b0; lr = 1'b0; dat = 1'b0; fp = 1'b0; cw = 1'b0;
      if (m_phase == 2) begin
         s = (m_t / 4) % 64; ft = m_t % 256; f = m_t / 256;
         bc   = (m_t % 4) >= 2;
         lr   = s >= 32;
         half = s % 32;
         smp  = m_mute ? 16'h0000 : mem[f % 64];
         if (half >= 1 && half <= 16) dat = smp[16 - half];
         fp = (ft == 0);
         a  = 6'(((ft >= 253) ? f + 1 : f) % 64);
         cw = (ft == 253) && ((f + 1) % 64 == 0);
      end
      return {a, bc, lr, dat, (m_phase != 0), fp, cw, m_mc};
   endfunction

   logic [27:0] dut_vec;
   assign dut_vec = {smp_addr, bclk, pblrc, pbdat, busy, frame_pulse, clip_wrap, mute_cnt};

   logic [15:0] cap_l [0:255];
   logic [15:0] cap_r [0:255];
   int          rises = 0, wraps = 0;
   logic        prev_bclk = 1'b0;

   always @(negedge clk) begin : cmp
      int f, s, half;
      if (!rst) begin
         check("outputs", {4'b0, dut_vec}, {4'b0, exp_vec()});
         if (m_phase == 2) begin
            f = m_t / 256; s = (m_t / 4) % 64; half = s % 32;
            if (f < 256 && half >= 1 && half <= 16) begin
               if (s < 32) cap_l[f][16 - half] <= pbdat;
               else        cap_r[f][16 - half] <= pbdat;
            end
            if (m_t < 130 * 256) begin
               if (bclk && !prev_bclk) rises++;
               if (clip_wrap) wraps++;
            end
         end
      end
      prev_bclk <= bclk;
   end

   task automatic wait_play(input int fr, input int ft);
      int n;
      n = 0;
      while (!(m_phase == 2 && m_t == fr * 256 + ft) && n < 40000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40000) begin
         checks++; errors++;
         $display("FAIL wait_play: frame %0d tick %0d never reached", fr, ft);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'(i);
      mem[5] = 16'hA5C3;
      rst = 1'b1; play_en = 1'b0; clip_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_outputs", {4'b0, dut_vec}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_outputs", {4'b0, dut_vec}, 32'h0);
      play_en = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_without_clip_valid", {31'b0, busy}, 32'h0);
      clip_valid = 1'b1;

      wait_play(0, 0);
      check("first_frame_pulse", {26'b0, smp_addr, frame_pulse}, 32'h1);
      wait_play(2, 0);
      check("frame0_left", {16'b0, cap_l[0]}, 32'h0000);
      check("frame1_left", {16'b0, cap_l[1]}, 32'h0001);
      check("frame1_right", {16'b0, cap_r[1]}, 32'h0001);
      wait_play(5, 127);
      check("pblrc_slot31", {31'b0, pblrc}, 32'h0);
      wait_play(5, 128);
      check("pblrc_slot32", {31'b0, pblrc}, 32'h1);
      wait_play(6, 0);
      check("frame5_left", {16'b0, cap_l[5]}, 32'hA5C3);
      check("frame5_right", {16'b0, cap_r[5]}, 32'hA5C3);

      wait_play(130, 0);
      check("clip_wrap_count", wraps, 2);
      check("bclk_rises", rises, 130 * 64);
      wait_play(130, 128);
      clip_valid = 1'b0;
      wait_play(133, 128);
      clip_valid = 1'b1;
      wait_play(135, 0);
      check("frame130_intact", {cap_l[130], cap_r[130]}, {16'd2, 16'd2});
      check("muted_131", {cap_l[131], cap_r[131]}, 32'h0);
      check("muted_132", {cap_l[132], cap_r[132]}, 32'h0);
      check("muted_133", {cap_l[133], cap_r[133]}, 32'h0);
      check("after_mute_134", {cap_l[134], cap_r[134]}, {16'd6, 16'd6});
      check("mute_cnt", {16'b0, mute_cnt}, 32'd3);

      // stop mid-frame: frame runs to completion, then idle
      wait_play(135, 40);
      play_en = 1'b0;
      wait_play(135, 255);
      check("stopping_busy", {30'b0, busy, bclk}, 32'h3);
      @(negedge clk);
      check("stopped", {24'b0, smp_addr, busy, bclk}, 32'h0);
      repeat (3) @(negedge clk);
      play_en = 1'b1;

      // drop and re-assert within a frame: no gap
      wait_play(2, 40);
      play_en = 1'b0;
      wait_play(2, 160);
      play_en = 1'b1;
      wait_play(3, 0);
      check("resume_no_gap", {30'b0, busy, frame_pulse}, 32'h3);

      // asynchronous reset mid-frame
      wait_play(4, 80);
      #1 rst = 1'b1;
      #1 check("async_reset", {4'b0, dut_vec}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_play(0, 0);
      check("restart_addr", {25'b0, smp_addr, frame_pulse}, 32'h1);
      wait_play(1, 0);
      check("restart_addr1", {26'b0, smp_addr}, 32'h1);
      wait_play(2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2s_clip_player.md
I2S_CLIP_PLAYER -- requirements
Module: i2s_clip_player

Interface
REQ-001 Parameter CLIP_LEN, default 64: number of samples in the clip buffer, power of two.
REQ-002 Parameter SAMPLE_BITS, default 16: sample width, at most 31.
REQ-003 The block SHALL have these ports (clock and reset first):
- clk  in  1: master clock, 256x sample rate (mclk domain).
- rst  in  1: reset, asynchronous, active-high.
- play_en  in  1: level; request playback.
- clip_valid  in  1: level from the BRAM loader; clip buffer contents are complete.
- smp_addr  out  $clog2(CLIP_LEN): sample buffer read address.
- smp_data  in  SAMPLE_BITS: read data, valid exactly 1 clk after smp_addr changes.
- audio_I2S_bclk  out  1: bit clock.
- audio_I2S_pblrc  out  1: word select; 0 = left, 1 = right.
- audio_I2S_pbdat  out  1: serial playback data.
- busy  out  1: state is not IDLE.
- frame_pulse  out  1: 1-clk pulse at each frame start.
- clip_wrap  out  1: 1-clk pulse when smp_addr wraps from CLIP_LEN-1 to 0.
- mute_cnt  out  16: count of frames muted because clip_valid was low.

Function
REQ-004 The block SHALL be a single clk domain; all outputs SHALL be registered.
REQ-005 States SHALL be IDLE, PREFETCH, PLAY and STOPPING.
REQ-006 IDLE -> PREFETCH SHALL occur when play_en=1 and clip_valid=1; otherwise the block SHALL remain in IDLE.
- In IDLE: bclk=0, pblrc=0, pbdat=0, smp_addr=0.
REQ-007 PREFETCH SHALL hold smp_addr=0 for 2 clk, latch smp_data into the sample register, then enter PLAY with div=0 and slot=0.
REQ-008 In PLAY, a 2-bit divider div SHALL increment every clk, and bclk SHALL equal div[1] (clk/4, 50% duty).
REQ-009 A 6-bit slot counter SHALL increment on each div 3->0 transition (bclk falling edge) and wrap 63->0; one frame = 64 bclk = 256 clk.
REQ-010 pblrc SHALL be 0 for slots 0-31 and 1 for slots 32-63.
REQ-011 pbdat SHALL carry I2S format with a one-bit delay:
- slot 1..SAMPLE_BITS: sample[SAMPLE_BITS-slot], MSB first.
- slot 33..32+SAMPLE_BITS: the same sample, MSB first (mono, duplicated to both channels).
- all other slots: 0.
REQ-012 pblrc and pbdat SHALL change only on bclk falling edges.
REQ-013 Fetch timing: at slot 63 with div=0, smp_addr SHALL advance to (smp_addr+1) mod CLIP_LEN.
- At div=2, smp_data SHALL be latched into a pending register.
- At the slot 63->0 transition, pending SHALL be moved into the sample register.
REQ-014 clip_wrap SHALL pulse on the clk where smp_addr goes from CLIP_LEN-1 to 0.
REQ-015 frame_pulse SHALL pulse on the clk where slot goes 63->0, and on PREFETCH->PLAY.
REQ-016 If clip_valid=0 at a frame boundary, that frame SHALL transmit all zeros and mute_cnt SHALL increment, saturating at 0xFFFF.
- smp_addr SHALL still advance.
REQ-017 play_en falling in PLAY SHALL move the block to STOPPING.
- STOPPING SHALL finish the current frame, then enter IDLE at slot 63->0 with bclk=0.
- play_en re-asserted during STOPPING SHALL return the block to PLAY without a gap.
REQ-018 clip_valid falling mid-frame SHALL NOT alter the frame in progress.
REQ-019 busy SHALL be 1 in PREFETCH, PLAY and STOPPING.

Reset
REQ-020 On rst assertion, at any time including mid-frame, the block SHALL immediately enter IDLE.
- All outputs, div, slot, sample, pending and mute_cnt SHALL go to 0.
REQ-021 After rst deasserts, the block SHALL wait in IDLE until the REQ-006 condition holds.

Verification
REQ-022 Buffer = address value (sample[n]=n), play_en=1, clip_valid=1 -> frame 0:
- bclk period 4 clk.
- pbdat slots 1-16 = 0x0000; frame 1 slots 1-16 and 33-48 = 0x0001.
REQ-023 sample[5]=0xA5C3 -> in frame 5, slots 1-16 and 33-48 SHALL both serialize 1010010111000011.
- pblrc rises at the start of slot 32.
REQ-024 Run 130 frames -> clip_wrap pulses exactly twice, at frames 63->64 and 127->128.
- No gap in bclk.
REQ-025 Hold clip_valid=0 for 3 frame boundaries -> those 3 frames are all zero and mute_cnt=3.
- The next frame plays sample[k+3], where k is the first muted frame index.
REQ-026 Drop play_en at slot 10 -> frame completes, then IDLE with bclk=0 and busy=0 at frame end.
- A second case re-asserts play_en at slot 40 -> playback continues without a gap.
REQ-027 Assert rst at slot 20 -> all outputs are 0 within the same cycle.
- After rst release with play_en=1, playback restarts at smp_addr=0.
